// File: rtl/fsm_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fsm_seq_ctrl                                               |
// | Description : Sequencer and lockstep checker for the 0->3->{2,5}->...    |
// |               sequence FSM. Holds the case, gate-level and ROM versions  |
// |               in reset, releases them together, drives a programmed bit  |
// |               pattern onto their shared input and compares each decoded  |
// |               state against an internal golden model on every cycle.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// The golden-model output is named expect_state because "expect" is a
// reserved SystemVerilog keyword and cannot be used as a plain port name.
module fsm_seq_ctrl #(
  parameter int PW    = 16,  // pattern width, maximum steps per run
  parameter int CNT_W = 5    // step counter width, 2**CNT_W > PW
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active low
  input  logic             start,
  input  logic [PW-1:0]    pattern,
  input  logic [CNT_W-1:0] len,
  input  logic [2:0]       s_case,
  input  logic [2:0]       s_gate,
  input  logic [2:0]       s_mem,
  output logic             fsm_res,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err,          // {mem, gate, case}
  output logic [CNT_W-1:0] fail_step,
  output logic [2:0]       expect_state,
  output logic [CNT_W-1:0] step
);

  localparam logic [CNT_W-1:0] c_PW_LEN = CNT_W'(PW);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [PW-1:0]    r_pat;        // remaining pattern bits, next bit to drive in [0]
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_step;
  logic [2:0]       r_expect;
  logic [2:0]       r_err;
  logic [CNT_W-1:0] r_fail_step;
  logic             r_a;
  logic             r_fsm_res;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_len_clamped;
  logic             w_len_zero;
  logic             w_last;
  logic [2:0]       w_mism;
  logic [2:0]       w_err_next;
  logic [CNT_W-1:0] w_fail_next;
  logic [2:0]       w_golden_next;

  // Golden transition function of the sequence FSM; anything outside the
  // legal state set falls back to state 0.
  function automatic logic [2:0] f_golden_next(input logic [2:0] cur, input logic ain);
    logic [2:0] nxt;
    case (cur)
      3'd0:    nxt = 3'd3;
      3'd3:    nxt = ain ? 3'd5 : 3'd2;
      3'd5:    nxt = 3'd2;
      3'd2:    nxt = 3'd4;
      3'd4:    nxt = ain ? 3'd3 : 3'd0;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // Length clamp, last-step detect, mismatch vector and golden advance.
  always_comb begin
    w_len_clamped = (len > c_PW_LEN) ? c_PW_LEN : len;
    w_len_zero    = (w_len_clamped == c_ZERO);
    w_last        = (r_step == (r_len - c_ONE));
    // Illegal encodings (1, 6, 7) can never equal the golden state, so they flag.
    w_mism        = {(s_mem != r_expect), (s_gate != r_expect), (s_case != r_expect)};
    w_err_next    = r_err | w_mism;
    // Only the first mismatch of a run records its step index.
    w_fail_next   = ((r_err == 3'b000) && (w_mism != 3'b000)) ? r_step : r_fail_step;
    w_golden_next = f_golden_next(r_expect, r_a);
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Controller next-state logic; start is honoured only in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_len_zero ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they change on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm_res <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fsm_res <= (w_next == ST_RUN) || (w_next == ST_CHECK);
      r_busy    <= (w_next == ST_RUN) || (w_next == ST_CHECK);
      r_done    <= (w_next == ST_DONE);
    end
  end

  // Run datapath: pattern shifter, step counter, golden model and error capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat       <= '0;
      r_len       <= '0;
      r_step      <= '0;
      r_expect    <= 3'd0;
      r_err       <= 3'b000;
      r_fail_step <= '0;
      r_a         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Bit 0 goes straight out on a; the shifter keeps bits 1.. ready.
            r_pat       <= pattern >> 1;
            r_len       <= w_len_clamped;
            r_step      <= '0;
            r_expect    <= 3'd0;
            r_err       <= 3'b000;
            r_fail_step <= '0;
            r_a         <= w_len_zero ? 1'b0 : pattern[0];
          end
        end
        ST_RUN: begin
          r_err       <= w_err_next;
          r_fail_step <= w_fail_next;
          r_expect    <= w_golden_next;
          // Step runs on to L so the final CHECK compare reports step L.
          r_step      <= r_step + c_ONE;
          if (w_last) begin
            r_a <= 1'b0;
          end else begin
            r_a   <= r_pat[0];
            r_pat <= r_pat >> 1;
          end
        end
        ST_CHECK: begin
          // Final-state compare only; the golden model holds.
          r_err       <= w_err_next;
          r_fail_step <= w_fail_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign fsm_res      = r_fsm_res;
  assign a            = r_a;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign fail_step    = r_fail_step;
  assign expect_state = r_expect;
  assign step         = r_step;

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fsm_seq_ctrl                                            |
// | Description : Self-checking bench for fsm_seq_ctrl with three stand-in   |
// |               sequence FSMs and per-implementation fault injection.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fsm_seq_ctrl;

  localparam int PW    = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PW-1:0]    pattern;
  logic [CNT_W-1:0] len;
  logic [2:0]       s_case, s_gate, s_mem;
  logic             fsm_res, a, busy, done;
  logic [2:0]       err;
  logic [CNT_W-1:0] fail_step;
  logic [2:0]       expect_state;
  logic [CNT_W-1:0] step;

  int n_checks = 0;
  int n_pass   = 0;

  // Fault-injection knobs for the stand-in FSM outputs.
  int         g_cyc      = -1;
  int         g_inj_impl = -1;
  int         g_inj_k    = 0;
  logic [2:0] g_inj_mask = 3'd0;
  bit         g_gate_raw = 1'b0;

  logic [2:0] fsm_st = 3'd0;

  fsm_seq_ctrl #(.PW(PW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .len          (len),
    .s_case       (s_case),
    .s_gate       (s_gate),
    .s_mem        (s_mem),
    .fsm_res      (fsm_res),
    .a            (a),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fail_step    (fail_step),
    .expect_state (expect_state),
    .step         (step)
  );

  always #5 clk = ~clk;

  // Sequence FSM rules written directly from the state diagram.
  function automatic int ref_next(input int s, input logic b);
    case (s)
      0:       return 3;
      3:       return b ? 5 : 2;
      5:       return 2;
      2:       return 4;
      4:       return b ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  // Stand-in for the three FSM implementations, clocked by the DUT's reset and input.
  always @(posedge clk) begin
    if (!fsm_res) fsm_st <= 3'd0;
    else          fsm_st <= 3'(ref_next(int'(fsm_st), a));
  end

  // Decoded outputs, with optional raw-encoding or one-cycle corruption.
  always_comb begin
    s_case = fsm_st;
    s_mem  = fsm_st;
    s_gate = (g_gate_raw && fsm_st == 3'd0) ? 3'd2 : fsm_st;
    if (g_cyc == g_inj_k) begin
      if (g_inj_impl == 0) s_case = s_case ^ g_inj_mask;
      if (g_inj_impl == 1) s_gate = s_gate ^ g_inj_mask;
      if (g_inj_impl == 2) s_mem  = s_mem  ^ g_inj_mask;
    end
  end

  // One full run from start to back in IDLE, checked cycle by cycle.
  task automatic do_run(input logic [PW-1:0] pat, input logic [CNT_W-1:0] ln,
                        input int inj_impl, input int inj_k, input logic [2:0] inj_mask,
                        input bit gate_raw, input bit mid_start, input string tag);
    int         L;
    int         seq   [0:PW];
    logic [2:0] cum_err[0:PW+1];
    int         cum_fs [0:PW+1];
    logic [2:0] e;
    int         fs;
    int         v;
    logic       exp_a;
    L = (int'(ln) > PW) ? PW : int'(ln);
    seq[0] = 0;
    for (int k = 1; k <= L; k++) seq[k] = ref_next(seq[k-1], pat[k-1]);
    // cum_err[k]: flags expected after k compares.
    e = 3'b000; fs = 0;
    cum_err[0] = e; cum_fs[0] = fs;
    for (int k = 0; k <= L; k++) begin
      for (int x = 0; x < 3; x++) begin
        v = seq[k];
        if (x == 1 && gate_raw && v == 0) v = 2;
        if (x == inj_impl && k == inj_k) v = v ^ int'(inj_mask);
        if (v != seq[k]) begin
          if (e == 3'b000) fs = k;
          e[x] = 1'b1;
        end
      end
      cum_err[k+1] = e; cum_fs[k+1] = fs;
    end

    @(negedge clk);
    g_inj_impl = inj_impl; g_inj_k = inj_k; g_inj_mask = inj_mask; g_gate_raw = gate_raw;
    start = 1'b1; pattern = pat; len = ln;
    @(posedge clk); #1;
    start = 1'b0; pattern = PW'($urandom); len = CNT_W'($urandom);
    g_cyc = 0;
    exp_a = (L > 0) ? pat[0] : 1'b0;
    n_checks++;
    if (busy !== 1'b1 || step !== '0 || expect_state !== 3'd0 || err !== 3'b000 ||
        fail_step !== '0 || fsm_res !== 1'b1 || done !== 1'b0 || a !== exp_a)
      $display("FAIL %s accept: busy=%b step=%0d exp=%0d err=%b fs=%0d res=%b done=%b a=%b want 1 0 0 000 0 1 0 %b",
               tag, busy, step, expect_state, err, fail_step, fsm_res, done, a, exp_a);
    else n_pass++;

    for (int k = 1; k <= L + 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      g_cyc = k;
      if (k <= L) begin
        exp_a = (k < L) ? pat[k] : 1'b0;
        n_checks++;
        if (step !== CNT_W'(k) || expect_state !== 3'(seq[k]))
          $display("FAIL %s k=%0d step/expect: got %0d/%0d want %0d/%0d", tag, k, step, expect_state, k, seq[k]);
        else n_pass++;
        n_checks++;
        if (a !== exp_a)
          $display("FAIL %s k=%0d a: got %b want %b", tag, k, a, exp_a);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || fsm_res !== 1'b1)
          $display("FAIL %s k=%0d busy/done/fsm_res: got %b%b%b want 101", tag, k, busy, done, fsm_res);
        else n_pass++;
      end else if (k == L + 1) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
          $display("FAIL %s done pulse: done=%b busy=%b want 1 0", tag, done, busy);
        else n_pass++;
        n_checks++;
        if (expect_state !== 3'(seq[L]) || step !== CNT_W'(L))
          $display("FAIL %s final expect/step: got %0d/%0d want %0d/%0d", tag, expect_state, step, seq[L], L);
        else n_pass++;
      end else begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || fsm_res !== 1'b0)
          $display("FAIL %s idle after run: done=%b busy=%b res=%b want 000", tag, done, busy, fsm_res);
        else n_pass++;
      end
      if (k <= L + 1) begin
        n_checks++;
        if (err !== cum_err[k] || fail_step !== CNT_W'(cum_fs[k]))
          $display("FAIL %s k=%0d err/fail_step: got %b/%0d want %b/%0d", tag, k, err, fail_step, cum_err[k], cum_fs[k]);
        else n_pass++;
      end
      if (mid_start && k == 4) begin
        start = 1'b1; pattern = ~pat; len = 5'd3;
      end
    end
    g_cyc = -1; g_inj_impl = -1; g_gate_raw = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pattern = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (fsm_res !== 1'b0 || a !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 3'b000 ||
        fail_step !== '0 || expect_state !== 3'd0 || step !== '0)
      $display("FAIL reset values: res=%b a=%b busy=%b done=%b err=%b fs=%0d exp=%0d step=%0d want all 0",
               fsm_res, a, busy, done, err, fail_step, expect_state, step);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || fsm_res !== 1'b0)
      $display("FAIL idle without start: busy=%b res=%b want 0 0", busy, fsm_res);
    else n_pass++;
  endtask

  task automatic test_zero_pattern();
    do_run(16'h0000, 5'd5, -1, 0, 3'd0, 1'b0, 1'b0, "pat0000");
  endtask

  task automatic test_pattern_12();
    do_run(16'h0012, 5'd5, -1, 0, 3'd0, 1'b0, 1'b0, "pat0012");
  endtask

  task automatic test_gate_raw();
    do_run(16'h0000, 5'd5, -1, 0, 3'd0, 1'b1, 1'b0, "gate_raw");
  endtask

  task automatic test_len_zero();
    do_run(16'hA5A4, 5'd0, -1, 0, 3'd0, 1'b0, 1'b0, "len0");
  endtask

  task automatic test_clamp_ignored_start();
    do_run(16'hB36D, 5'd20, -1, 0, 3'd0, 1'b0, 1'b1, "clamp20");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    g_inj_impl = 0; g_inj_k = 0; g_inj_mask = 3'd1;
    start = 1'b1; pattern = 16'h0012; len = 5'd5;
    @(posedge clk); #1;
    start = 1'b0; g_cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      g_cyc = k;
    end
    n_checks++;
    if (step !== 5'd3 || err !== 3'b001)
      $display("FAIL midrun before reset: step=%0d err=%b want 3 001", step, err);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (fsm_res !== 1'b0 || a !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 3'b000 ||
        fail_step !== '0 || expect_state !== 3'd0 || step !== '0)
      $display("FAIL async reset: res=%b a=%b busy=%b done=%b err=%b fs=%0d exp=%0d step=%0d want all 0",
               fsm_res, a, busy, done, err, fail_step, expect_state, step);
    else n_pass++;
    g_cyc = -1; g_inj_impl = -1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) reset = 1'b1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL no done after reset: cycle %0d done=%b busy=%b want 0 0", k, done, busy);
      else n_pass++;
    end
    do_run(16'h0012, 5'd5, -1, 0, 3'd0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [PW-1:0]    p;
    logic [CNT_W-1:0] l;
    int               Lc, impl, kk;
    logic [2:0]       m;
    for (int r = 0; r < 30; r++) begin
      p  = PW'($urandom);
      l  = CNT_W'($urandom_range(0, 20));
      Lc = (int'(l) > PW) ? PW : int'(l);
      impl = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
      kk = int'($urandom_range(0, Lc));
      m  = 3'($urandom_range(1, 7));
      do_run(p, l, impl, kk, m, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero_pattern();
    test_pattern_12();
    test_gate_raw();
    test_len_zero();
    test_clamp_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
